// File: rtl/switches_ctrl_pkg.sv
// Shared register addresses and debounce-length type for the slide-switch controller.
package switches_ctrl_pkg;

    localparam logic [1:0] ADDR_STATE  = 2'd0;
    localparam logic [1:0] ADDR_FLAGS  = 2'd1;
    localparam logic [1:0] ADDR_MASK   = 2'd2;
    localparam logic [1:0] ADDR_DEBLEN = 2'd3;

    typedef logic [3:0] deb_len_t;

    // A programmed length of zero behaves as a single-tick debounce.
    function automatic deb_len_t eff_len_of(input deb_len_t len);
        return (len == 4'd0) ? 4'd1 : len;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch: 2-flop synchroniser, tick-driven debounce counter, stable bit and change pulse.
module switch_debouncer
    import switches_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sw,
    input  logic       tick,
    input  logic [3:0] eff_len,
    output logic       st,
    output logic       chg
);

    logic       sync_q1;
    logic       sync_q2;
    logic [3:0] cnt;
    logic [4:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt} + 5'd1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= 4'd0;
            st      <= 1'b0;
            chg     <= 1'b0;
        end else begin
            sync_q1 <= sw;
            sync_q2 <= sync_q1;
            chg     <= 1'b0;
            if (tick) begin
                if (sync_q2 == st) begin
                    cnt <= 4'd0;
                end else if (cnt_inc >= {1'b0, eff_len}) begin
                    st  <= ~st;
                    cnt <= 4'd0;
                    chg <= 1'b1;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/module_switches_ctrl.sv
// Memory-mapped slide-switch controller: per-switch debounce, sticky change flags,
// maskable level interrupt and a four-word register window.
module module_switches_ctrl
    import switches_ctrl_pkg::*;
#(
    parameter int       N_SW        = 16,
    parameter int       TICK_DIV    = 100000,
    parameter deb_len_t DEB_LEN_RST = 4'd4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_SW-1:0] sw_i,
    input  logic            we_i,
    input  logic            re_i,
    input  logic [1:0]      addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o,
    output logic            rvalid_o,
    output logic            irq_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]   presc;
    logic            tick;
    deb_len_t        deb_len;
    logic [3:0]      eff_len;
    logic [N_SW-1:0] st;
    logic [N_SW-1:0] chg;
    logic [N_SW-1:0] flags;
    logic [N_SW-1:0] mask;
    logic [N_SW-1:0] clr_bits;
    logic [31:0]     rd_word;
    logic            wr_flags;
    logic            wr_mask;
    logic            wr_deblen;
    logic            unused_wdata;

    assign unused_wdata = ^wdata_i;

    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign eff_len = eff_len_of(deb_len);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_deb
        switch_debouncer u_deb (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .sw      (sw_i[i]),
            .tick    (tick),
            .eff_len (eff_len),
            .st      (st[i]),
            .chg     (chg[i])
        );
    end

    assign wr_flags  = we_i && (addr_i == ADDR_FLAGS);
    assign wr_mask   = we_i && (addr_i == ADDR_MASK);
    assign wr_deblen = we_i && (addr_i == ADDR_DEBLEN);
    assign clr_bits  = wr_flags ? wdata_i[N_SW-1:0] : '0;

    // Reads see register contents before any same-cycle write lands.
    always_comb begin
        rd_word = '0;
        case (addr_i)
            ADDR_STATE:  rd_word = 32'(st);
            ADDR_FLAGS:  rd_word = 32'(flags);
            ADDR_MASK:   rd_word = 32'(mask);
            ADDR_DEBLEN: rd_word = {28'd0, deb_len};
            default:     rd_word = '0;
        endcase
    end

    // Bus handshake: re_i sampled at edge n returns rdata_o with rvalid_o high for exactly
    // the following cycle; rdata_o holds its last value otherwise. Writes apply at edge n.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flags    <= '0;
            mask     <= '0;
            deb_len  <= DEB_LEN_RST;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
            irq_o    <= 1'b0;
        end else begin
            // A new change event beats a same-cycle clear.
            flags    <= (flags & ~clr_bits) | chg;
            if (wr_mask) begin
                mask <= wdata_i[N_SW-1:0];
            end
            if (wr_deblen) begin
                deb_len <= wdata_i[3:0];
            end
            if (re_i) begin
                rdata_o <= rd_word;
            end
            rvalid_o <= re_i;
            irq_o    <= |(flags & mask);
        end
    end

endmodule

// File: tb/tb_module_switches_ctrl.sv
// Bench for module_switches_ctrl with a fast prescaler; reads are checked against a queue.
module tb_module_switches_ctrl;

  localparam int N_SW     = 16;
  localparam int TICK_DIV = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N_SW-1:0] sw_i;
  logic            we_i;
  logic            re_i;
  logic [1:0]      addr_i;
  logic [31:0]     wdata_i;
  logic [31:0]     rdata_o;
  logic            rvalid_o;
  logic            irq_o;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  module_switches_ctrl #(
    .N_SW        (N_SW),
    .TICK_DIV    (TICK_DIV),
    .DEB_LEN_RST (4'd4)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sw_i     (sw_i),
    .we_i     (we_i),
    .re_i     (re_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .irq_o    (irq_o)
  );

  // clock / reset-relative edge counter
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard: every rvalid pulse must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_spurious", 32'd1, 32'd0);
      end else begin
        chk(tag_q.pop_front(), rdata_o, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic bus(input logic w, input logic r, input logic [1:0] a,
                     input logic [31:0] d, input logic [31:0] e, input string tag);
    @(posedge clk_i); #1;
    we_i = w; re_i = r; addr_i = a; wdata_i = d;
    if (r) begin
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
    @(posedge clk_i); #1;
    we_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
    bus(1'b0, 1'b1, a, 32'd0, e, tag);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d, 32'd0, "");
  endtask

  // leaves the caller just after an edge on which the prescaler tick fired
  task automatic wait_tick_edge();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * TICK_DIV && !found; i++) begin
      @(posedge clk_i); #1;
      if (cyc % TICK_DIV == 0) found = 1'b1;
    end
    if (!found) chk("tick_align", 32'd0, 32'd1);
  endtask

  initial begin
    rst_i = 1'b0; sw_i = '0; we_i = 1'b0; re_i = 1'b0; addr_i = 2'd0; wdata_i = '0;
    #12;
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b1;

    // register defaults
    rd(2'd0, 32'h0, "st_reset");
    rd(2'd1, 32'h0, "flags_reset");
    rd(2'd2, 32'h0, "mask_reset");
    rd(2'd3, 32'h4, "deblen_reset");
    chk("irq_idle", 32'(irq_o), 32'd0);

    // clean press with deb_len=3: stable by edge 11..14 after the pin moves
    wr(2'd3, 32'd3);
    @(posedge clk_i); #1; sw_i[0] = 1'b1;
    repeat (7) @(posedge clk_i);
    rd(2'd0, 32'h0, "st_early");
    repeat (5) @(posedge clk_i);
    rd(2'd0, 32'h1, "st_rise");
    rd(2'd1, 32'h1, "flag_rise");

    // release, clear, then a short glitch that must be ignored
    sw_i[0] = 1'b0;
    repeat (20) @(posedge clk_i);
    wr(2'd1, 32'h0000_FFFF);
    rd(2'd0, 32'h0, "st_fall");
    rd(2'd1, 32'h0, "flags_cleared");
    @(posedge clk_i); #1; sw_i[5] = 1'b1;
    repeat (7) @(posedge clk_i);
    #1; sw_i[5] = 1'b0;
    repeat (20) @(posedge clk_i);
    rd(2'd0, 32'h0, "glitch_st");
    rd(2'd1, 32'h0, "glitch_flags");

    // interrupt raise and clear timing
    sw_i[0] = 1'b1;
    repeat (20) @(posedge clk_i);
    wr(2'd2, 32'h1);
    @(negedge clk_i); chk("irq_lag", 32'(irq_o), 32'd0);
    @(negedge clk_i); chk("irq_set", 32'(irq_o), 32'd1);
    wr(2'd1, 32'h1);
    @(negedge clk_i); chk("irq_hold", 32'(irq_o), 32'd1);
    @(negedge clk_i); chk("irq_clr", 32'(irq_o), 32'd0);
    rd(2'd1, 32'h0, "flags_w1c");

    // clear lands on the same edge the change event sets the flag
    wr(2'd3, 32'd1);
    wait_tick_edge();
    sw_i[0] = 1'b0;
    repeat (3) @(posedge clk_i);
    wr(2'd1, 32'h1);
    rd(2'd1, 32'h1, "flag_set_wins");
    @(negedge clk_i); chk("irq_set_wins", 32'(irq_o), 32'd1);
    wr(2'd1, 32'h0000_FFFF);
    rd(2'd1, 32'h0, "flags_clr2");

    // deb_len=0 acts as one tick
    wr(2'd3, 32'd0);
    rd(2'd3, 32'h0, "deblen_zero");
    wait_tick_edge();
    sw_i[15] = 1'b1;
    repeat (2) @(posedge clk_i);
    rd(2'd0, 32'h0, "fast_before");
    rd(2'd0, 32'h8000, "fast_after");

    // same-address read+write, upper bits
    wr(2'd2, 32'h0000_00F0);
    bus(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0000_00F0, "rw_same_addr");
    rd(2'd2, 32'h0000_FFFF, "mask_upper");
    wr(2'd3, 32'hFFFF_FFF7);
    rd(2'd3, 32'h7, "deblen_upper");
    @(negedge clk_i); chk("irq_pre_rst", 32'(irq_o), 32'd1);

    // asynchronous reset in the middle of debouncing every switch
    sw_i = 16'hFFFF;
    repeat (6) @(posedge clk_i);
    #3 rst_i = 1'b0;
    #1;
    chk("async_rst_rdata", rdata_o, 32'd0);
    chk("async_rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("async_rst_irq", 32'(irq_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (12) @(posedge clk_i);
    rd(2'd0, 32'h0, "rerun_st_early");
    rd(2'd3, 32'h4, "rerun_deblen");
    rd(2'd0, 32'h0000_FFFF, "rerun_st");
    rd(2'd1, 32'h0000_FFFF, "rerun_flags");
    rd(2'd2, 32'h0, "rerun_mask");
    chk("rerun_irq", 32'(irq_o), 32'd0);

    repeat (3) @(posedge clk_i);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
